// File: rtl/clock_set_pkg.sv
// Shared encodings, field limits and widths for the HH:MM:SS set-mode timekeeper.
package clock_set_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;
    localparam int SEC_MAX  = 59;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_SEC  = 2'd3
    } mode_t;

    // Long press walks RUN -> hour -> minute -> second -> RUN.
    function automatic mode_t next_mode(input mode_t cur);
        case (cur)
            MODE_RUN:      next_mode = MODE_SET_HOUR;
            MODE_SET_HOUR: next_mode = MODE_SET_MIN;
            MODE_SET_MIN:  next_mode = MODE_SET_SEC;
            default:       next_mode = MODE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button pulses in, time/mode/blink out, between short_or_long and the display driver.
interface clock_set_if;

    logic       inc_short;
    logic       inc_long;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [1:0] mode;
    logic       blink;

    modport master (
        output inc_short, inc_long,
        input  hour, minute, second, mode, blink
    );

    modport slave (
        input  inc_short, inc_long,
        output hour, minute, second, mode, blink
    );

endinterface

// File: rtl/clock_set_ctrl_mod_counter.sv
// Wrapping 0..MAX field counter; carry flags the increment that wraps.
module mod_counter #(
    parameter int WIDTH = 6,
    parameter int MAX   = 59
) (
    input  logic             clk_10000Hz,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic             carry
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    assign carry = inc && (value == MAX_V);

    always_ff @(posedge clk_10000Hz) begin
        if (rst) begin
            value <= '0;
        end else if (inc) begin
            value <= (value == MAX_V) ? '0 : value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// 24 h timekeeper with long-press field select and short-press field increment.
// Optional field blinking in set mode is enabled by defining BLINK_EN.
module clock_set_ctrl
    import clock_set_pkg::*;
#(
    parameter int TICK_DIV  = 10000,
    parameter int BLINK_DIV = 2500
) (
    input  logic        clk_10000Hz,
    input  logic        rst,
    clock_set_if.slave  bus
);

    if (TICK_DIV < 2 || BLINK_DIV < 1) begin : g_bad_params
        $error("clock_set_ctrl: TICK_DIV must be >= 2 and BLINK_DIV >= 1");
    end

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    mode_t              mode_q;
    logic [PW-1:0]      presc;
    logic               run;
    logic               tick;
    logic               set_short;
    logic               sec_inc, min_inc, hour_inc;
    logic               sec_carry, min_carry;
    logic [HOUR_W-1:0]  hour_v;
    logic [MIN_W-1:0]   min_v;
    logic [SEC_W-1:0]   sec_v;

    // A long press wins over both the tick and a simultaneous short press.
    always_comb begin
        run       = (mode_q == MODE_RUN);
        tick      = run && !bus.inc_long && (presc == PRESC_LAST);
        set_short = bus.inc_short && !bus.inc_long;
        sec_inc   = run ? tick      : (set_short && mode_q == MODE_SET_SEC);
        min_inc   = run ? sec_carry : (set_short && mode_q == MODE_SET_MIN);
        hour_inc  = run ? min_carry : (set_short && mode_q == MODE_SET_HOUR);
    end

    mod_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clk_10000Hz (clk_10000Hz),
        .rst         (rst),
        .inc         (sec_inc),
        .value       (sec_v),
        .carry       (sec_carry)
    );

    mod_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk_10000Hz (clk_10000Hz),
        .rst         (rst),
        .inc         (min_inc),
        .value       (min_v),
        .carry       (min_carry)
    );

    mod_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clk_10000Hz (clk_10000Hz),
        .rst         (rst),
        .inc         (hour_inc),
        .value       (hour_v),
        .carry       ()
    );

    // Prescaler idles at 0 outside RUN, so re-entering RUN gives a full second.
    always_ff @(posedge clk_10000Hz) begin
        if (rst) begin
            mode_q <= MODE_RUN;
            presc  <= '0;
        end else if (bus.inc_long) begin
            mode_q <= next_mode(mode_q);
            presc  <= '0;
        end else if (!run || presc == PRESC_LAST) begin
            presc  <= '0;
        end else begin
            presc  <= presc + PW'(1);
        end
    end

`ifdef BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_q;

    // Any button activity restarts the blink phase with the field visible.
    always_ff @(posedge clk_10000Hz) begin
        if (rst || run || bus.inc_long || bus.inc_short) begin
            blink_cnt <= '0;
            blink_q   <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_q   <= ~blink_q;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    assign bus.blink = blink_q;
`else
    assign bus.blink = 1'b1;
`endif

    assign bus.hour   = hour_v;
    assign bus.minute = min_v;
    assign bus.second = sec_v;
    assign bus.mode   = mode_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with TICK_DIV=10, BLINK_DIV=4.
module tb_clock_set_ctrl;

    logic clk_10000Hz = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    clock_set_if bus ();

    clock_set_ctrl #(.TICK_DIV(10), .BLINK_DIV(4)) dut (
        .clk_10000Hz (clk_10000Hz),
        .rst         (rst),
        .bus         (bus)
    );

    always #5 clk_10000Hz = ~clk_10000Hz;

    task automatic step(input int n);
        repeat (n) @(posedge clk_10000Hz);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    task automatic pulse(input logic s, input logic l);
        bus.inc_short = s;
        bus.inc_long  = l;
        step(1);
        bus.inc_short = 1'b0;
        bus.inc_long  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.hour, bus.minute, bus.second} !== 17'd0) begin
            errors++;
            $display("[TB] FAIL reset_time: got %0d:%0d:%0d want 0:0:0", bus.hour, bus.minute, bus.second);
        end
        checks++;
        if (bus.mode !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_mode: got %0d want 0", bus.mode);
        end
        checks++;
        if (bus.blink !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_blink: got %b want 1", bus.blink);
        end
    endtask

    task automatic test_run_minute();
        do_reset();
        for (int i = 1; i <= 600; i++) begin
            step(1);
            checks++;
            if (bus.blink !== 1'b1 || bus.mode !== 2'd0) begin
                errors++;
                $display("[TB] FAIL run_blink_mode cycle %0d: got blink=%b mode=%0d want 1/0", i, bus.blink, bus.mode);
            end
            if (i == 599) begin
                checks++;
                if (bus.minute !== 6'd0 || bus.second !== 6'd59) begin
                    errors++;
                    $display("[TB] FAIL run_599: got %0d:%0d want 0:59", bus.minute, bus.second);
                end
            end
        end
        checks++;
        if (bus.hour !== 5'd0 || bus.minute !== 6'd1 || bus.second !== 6'd0) begin
            errors++;
            $display("[TB] FAIL run_600: got %0d:%0d:%0d want 0:1:0", bus.hour, bus.minute, bus.second);
        end
        pulse(1'b1, 1'b0);
        checks++;
        if (bus.mode !== 2'd0 || bus.minute !== 6'd1 || bus.second !== 6'd0) begin
            errors++;
            $display("[TB] FAIL run_short_ignored: got mode=%0d %0d:%0d want 0 1:0", bus.mode, bus.minute, bus.second);
        end
    endtask

    task automatic test_midnight();
        do_reset();
        pulse(1'b0, 1'b1);
        repeat (23) pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        repeat (59) pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        repeat (59) pulse(1'b1, 1'b0);
        checks++;
        if (bus.mode !== 2'd3 || bus.hour !== 5'd23 || bus.minute !== 6'd59 || bus.second !== 6'd59) begin
            errors++;
            $display("[TB] FAIL preload: got mode=%0d %0d:%0d:%0d want 3 23:59:59", bus.mode, bus.hour, bus.minute, bus.second);
        end
        pulse(1'b0, 1'b1);
        checks++;
        if (bus.mode !== 2'd0) begin
            errors++;
            $display("[TB] FAIL back_to_run: got mode=%0d want 0", bus.mode);
        end
        step(9);
        checks++;
        if (bus.hour !== 5'd23 || bus.minute !== 6'd59 || bus.second !== 6'd59) begin
            errors++;
            $display("[TB] FAIL midnight_early: got %0d:%0d:%0d want 23:59:59", bus.hour, bus.minute, bus.second);
        end
        step(1);
        checks++;
        if ({bus.hour, bus.minute, bus.second} !== 17'd0) begin
            errors++;
            $display("[TB] FAIL midnight_wrap: got %0d:%0d:%0d want 0:0:0", bus.hour, bus.minute, bus.second);
        end
    endtask

    task automatic test_hour_wrap();
        do_reset();
        pulse(1'b0, 1'b1);
        repeat (24) pulse(1'b1, 1'b0);
        checks++;
        if (bus.hour !== 5'd0) begin
            errors++;
            $display("[TB] FAIL hour_wrap24: got %0d want 0", bus.hour);
        end
        pulse(1'b1, 1'b0);
        step(20);
        checks++;
        if (bus.mode !== 2'd1 || bus.hour !== 5'd1 || bus.minute !== 6'd0 || bus.second !== 6'd0) begin
            errors++;
            $display("[TB] FAIL hour_set25: got mode=%0d %0d:%0d:%0d want 1 1:0:0", bus.mode, bus.hour, bus.minute, bus.second);
        end
    endtask

    task automatic test_coincide();
        pulse(1'b1, 1'b1);
        checks++;
        if (bus.mode !== 2'd2 || bus.hour !== 5'd1 || bus.minute !== 6'd0) begin
            errors++;
            $display("[TB] FAIL long_short_same: got mode=%0d hour=%0d min=%0d want 2 1 0", bus.mode, bus.hour, bus.minute);
        end
        do_reset();
        step(9);
        pulse(1'b0, 1'b1);
        checks++;
        if (bus.mode !== 2'd1 || bus.second !== 6'd0) begin
            errors++;
            $display("[TB] FAIL long_on_tick: got mode=%0d sec=%0d want 1 0", bus.mode, bus.second);
        end
        step(15);
        checks++;
        if (bus.second !== 6'd0) begin
            errors++;
            $display("[TB] FAIL set_frozen: got sec=%0d want 0", bus.second);
        end
    endtask

    task automatic test_rst_mid_set();
        do_reset();
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        repeat (37) pulse(1'b1, 1'b0);
        checks++;
        if (bus.mode !== 2'd2 || bus.minute !== 6'd37 || bus.hour !== 5'd0) begin
            errors++;
            $display("[TB] FAIL set_min37: got mode=%0d %0d:%0d want 2 0:37", bus.mode, bus.hour, bus.minute);
        end
        do_reset();
        checks++;
        if (bus.mode !== 2'd0 || {bus.hour, bus.minute, bus.second} !== 17'd0) begin
            errors++;
            $display("[TB] FAIL rst_mid_set: got mode=%0d %0d:%0d:%0d want 0 0:0:0", bus.mode, bus.hour, bus.minute, bus.second);
        end
    endtask

    task automatic test_blink();
        do_reset();
        pulse(1'b0, 1'b1);
`ifdef BLINK_EN
        checks++;
        if (bus.blink !== 1'b1) begin
            errors++;
            $display("[TB] FAIL blink_enter: got %b want 1", bus.blink);
        end
        for (int i = 1; i <= 8; i++) begin
            step(1);
            checks++;
            if (bus.blink !== ((i >= 4 && i < 8) ? 1'b0 : 1'b1)) begin
                errors++;
                $display("[TB] FAIL blink_phase cycle %0d: got %b", i, bus.blink);
            end
        end
        step(4);
        checks++;
        if (bus.blink !== 1'b0) begin
            errors++;
            $display("[TB] FAIL blink_low: got %b want 0", bus.blink);
        end
        pulse(1'b1, 1'b0);
        checks++;
        if (bus.blink !== 1'b1) begin
            errors++;
            $display("[TB] FAIL blink_short_restart: got %b want 1", bus.blink);
        end
        step(3);
        checks++;
        if (bus.blink !== 1'b1) begin
            errors++;
            $display("[TB] FAIL blink_restart_hold: got %b want 1", bus.blink);
        end
        step(1);
        checks++;
        if (bus.blink !== 1'b0) begin
            errors++;
            $display("[TB] FAIL blink_restart_toggle: got %b want 0", bus.blink);
        end
`else
        for (int i = 1; i <= 12; i++) begin
            step(1);
            checks++;
            if (bus.blink !== 1'b1) begin
                errors++;
                $display("[TB] FAIL blink_const cycle %0d: got %b want 1", i, bus.blink);
            end
        end
`endif
    endtask

    initial begin
        bus.inc_short = 1'b0;
        bus.inc_long  = 1'b0;
        step(2);
        test_reset();
        test_run_minute();
        test_midnight();
        test_hour_wrap();
        test_coincide();
        test_rst_mid_set();
        test_blink();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
